// File: rtl/pipe_bus_pkg.sv
// Shared pipeline bus widths, field layouts and load-op encodings.
// Imported by every stage that produces or consumes the MEM-stage buses.
package pipe_bus_pkg;

  localparam int EX2MEM_W = 80;
  localparam int MEM2WB_W = 72;
  localparam int MEM2ID_W = 40;
  localparam int MEM2EX_W = 3;

  // MEM->WB field positions
  localparam int WB_PC_LSB     = 40;
  localparam int WB_WE_BIT     = 39;
  localparam int WB_WADDR_LSB  = 34;
  localparam int WB_RESULT_LSB = 2;
  localparam int WB_EXCEP_BIT  = 1;
  localparam int WB_ERTN_BIT   = 0;

  // MEM->ID field positions
  localparam int ID_RES_MEM_BIT = 39;
  localparam int ID_WE_BIT      = 38;
  localparam int ID_WADDR_LSB   = 33;
  localparam int ID_RESULT_LSB  = 1;
  localparam int ID_PENDING_BIT = 0;

  // Load op encodings, packed as {op_b, op_h, op_u}
  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_HU = 3'b011,
    LD_H  = 3'b010,
    LD_BU = 3'b101,
    LD_B  = 3'b100
  } load_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic [1:0]  addr_lo;
    logic        op_b;
    logic        op_h;
    logic        op_u;
    logic        excep_en;
    logic        ertn_flush;
    logic        mem_req;
    logic        srch_conflict;
  } ex_to_mem_t;

endpackage

// File: rtl/load_align.sv
// Combinational load-data extraction: picks the byte/half/word addressed by
// addr_lo and zero- or sign-extends it to 32 bits.
module load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic        op_b,
  input  logic        op_h,
  input  logic        op_u,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    if (op_b) begin
      result = {{24{byte_sel[7] & ~op_u}}, byte_sel};
    end else if (op_h) begin
      result = {{16{half_sel[15] & ~op_u}}, half_sel};
    end else begin
      result = rdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response, aligns load data and
// forwards to WB; responses of flushed requests are counted and discarded.
module mem_stage
  import pipe_bus_pkg::*;
#(
  parameter int CANCEL_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                ex_to_mem_valid,
  output logic                mem_allowin,
  input  logic [EX2MEM_W-1:0] ex_to_mem_bus,
  output logic [MEM2EX_W-1:0] mem_to_ex_bus,
  output logic [MEM2ID_W-1:0] mem_to_id_bus,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  input  logic                wb_allowin,
  output logic                mem_to_wb_valid,
  output logic [MEM2WB_W-1:0] mem_to_wb_bus
);

  localparam logic [CANCEL_W-1:0] CANCEL_MAX = '1;

  // Handshake: a stage transfers when its valid and the consumer's allowin are
  // both high at a rising edge; MEM holds its payload while allowin is low.
  ex_to_mem_t          pl;
  logic                mem_valid;
  logic                buf_valid;
  logic [31:0]         rdata_buf;
  logic [CANCEL_W-1:0] cancel_cnt;
  logic [CANCEL_W-1:0] cancel_next;

  logic        resp_mine;
  logic        swallow;
  logic        cancel_inc;
  logic        ready_go;
  logic        leave;
  logic        capture;
  logic        data_pending;
  logic [31:0] rdata;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign resp_mine       = data_sram_data_ok & (cancel_cnt == '0);
  assign swallow         = data_sram_data_ok & (cancel_cnt != '0);
  assign ready_go        = ~pl.mem_req | buf_valid | resp_mine;
  assign mem_allowin     = ~mem_valid | (ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid & ready_go;
  assign leave           = mem_to_wb_valid & wb_allowin;
  assign capture         = mem_valid & pl.mem_req & resp_mine & ~wb_allowin & ~buf_valid;
  assign cancel_inc      = flush & mem_valid & pl.mem_req & ~buf_valid & ~resp_mine;
  assign data_pending    = mem_valid & pl.res_from_mem & ~ready_go;

  assign rdata        = buf_valid ? rdata_buf : data_sram_rdata;
  assign final_result = pl.res_from_mem ? load_data : pl.alu_result;

  load_align u_load_align (
    .rdata   (rdata),
    .addr_lo (pl.addr_lo),
    .op_b    (pl.op_b),
    .op_h    (pl.op_h),
    .op_u    (pl.op_u),
    .result  (load_data)
  );

  // A coinciding swallow and increment leave the count unchanged.
  always_comb begin
    cancel_next = cancel_cnt;
    case ({cancel_inc, swallow})
      2'b10:   if (cancel_cnt != CANCEL_MAX) cancel_next = cancel_cnt + CANCEL_W'(1);
      2'b01:   cancel_next = cancel_cnt - CANCEL_W'(1);
      default: cancel_next = cancel_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid  <= 1'b0;
      pl         <= '0;
      buf_valid  <= 1'b0;
      rdata_buf  <= 32'h0;
      cancel_cnt <= '0;
    end else begin
      if (flush) begin
        mem_valid <= 1'b0;
      end else if (mem_allowin) begin
        mem_valid <= ex_to_mem_valid;
      end
      if (ex_to_mem_valid & mem_allowin) begin
        pl <= ex_to_mem_bus;
      end
      if (flush | leave) begin
        buf_valid <= 1'b0;
      end else if (capture) begin
        buf_valid <= 1'b1;
        rdata_buf <= data_sram_rdata;
      end
      cancel_cnt <= cancel_next;
    end
  end

  always_comb begin
    mem_to_wb_bus                          = '0;
    mem_to_wb_bus[WB_PC_LSB +: 32]         = pl.pc;
    mem_to_wb_bus[WB_WE_BIT]               = pl.rf_we;
    mem_to_wb_bus[WB_WADDR_LSB +: 5]       = pl.rf_waddr;
    mem_to_wb_bus[WB_RESULT_LSB +: 32]     = final_result;
    mem_to_wb_bus[WB_EXCEP_BIT]            = pl.excep_en;
    mem_to_wb_bus[WB_ERTN_BIT]             = pl.ertn_flush;

    mem_to_id_bus                          = '0;
    mem_to_id_bus[ID_RES_MEM_BIT]          = pl.res_from_mem & mem_valid;
    mem_to_id_bus[ID_WE_BIT]               = pl.rf_we & mem_valid;
    mem_to_id_bus[ID_WADDR_LSB +: 5]       = pl.rf_waddr;
    mem_to_id_bus[ID_RESULT_LSB +: 32]     = final_result;
    mem_to_id_bus[ID_PENDING_BIT]          = data_pending;

    mem_to_ex_bus = {pl.excep_en & mem_valid, pl.ertn_flush & mem_valid,
                     pl.srch_conflict & mem_valid};
  end

  cancel_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(cancel_inc && !swallow && cancel_cnt == CANCEL_MAX));

  no_stray_response: assert property (@(posedge clk) disable iff (reset)
    !(data_sram_data_ok && cancel_cnt == '0 && !(mem_valid && pl.mem_req && !buf_valid)));

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage sitting directly downstream of the EX stage.
- Accepts the EX→MEM bus after EX has had its data-SRAM request address-accepted, waits for `data_sram_data_ok`, and extracts/sign-extends load data.
- Forwards results to WB, and provides bypass/hazard information back to ID and exception status back to EX.
- Discards responses that belong to requests flushed by a WB exception/ertn.

Parameters:
- CANCEL_W, 2, width of the flushed-outstanding-response counter (max 2^CANCEL_W−1 pending discards).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  WB exception/ertn flush
- ex_to_mem_valid  in  1  EX has a valid instruction
- mem_allowin  out  1  MEM can accept this cycle
- ex_to_mem_bus  in  80  {pc[31:0], res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0], addr_lo[1:0], op_b, op_h, op_u, excep_en, ertn_flush, mem_req, srch_conflict} (MSB→LSB)
- mem_to_ex_bus  out  3  {excep_en&valid, ertn_flush&valid, srch_conflict&valid}
- mem_to_id_bus  out  40  {res_from_mem&valid, rf_we&valid, rf_waddr, final_result, data_pending}
- data_sram_data_ok  in  1  read/write response
- data_sram_rdata  in  32  load data
- wb_allowin  in  1  WB can accept
- mem_to_wb_valid  out  1  MEM result valid for WB
- mem_to_wb_bus  out  72  {pc, rf_we, rf_waddr, final_result, excep_en, ertn_flush}

Behaviour:
- **State registers:**
  - `mem_valid`
  - payload registers (the bus fields)
  - `buf_valid`, `rdata_buf[31:0]`: a response captured while WB stalls
  - `cancel_cnt[CANCEL_W-1:0]`
- **Reset:** all of the above are 0. Hence `mem_to_wb_valid` = 0, all `*_bus` validity-qualified bits = 0, and `mem_allowin` = 1.
- **Valid register:** `mem_valid` <= 0 on reset or flush; else if `mem_allowin`, `mem_valid` <= `ex_to_mem_valid`. Payload loads when `ex_to_mem_valid & mem_allowin`.
- **Response ownership:**
  - `resp_mine` = `data_sram_data_ok & (cancel_cnt==0)`.
  - When `data_sram_data_ok & cancel_cnt!=0`, the response is swallowed and `cancel_cnt` decrements.
- **Handshake:**
  - `ready_go` = `~mem_req | buf_valid | resp_mine`.
  - `mem_allowin` = `~mem_valid | ready_go & wb_allowin`.
  - `mem_to_wb_valid` = `mem_valid & ready_go`.
- **Response buffer:**
  - If `mem_valid & mem_req & resp_mine & ~wb_allowin & ~buf_valid`: `rdata_buf` <= `data_sram_rdata`, `buf_valid` <= 1.
  - `buf_valid` clears when the instruction leaves (`mem_to_wb_valid & wb_allowin`) or on flush.
- **Flush with request outstanding:** if flush occurs while `mem_valid & mem_req & ~buf_valid & ~resp_mine`, `cancel_cnt` increments.
  - If a swallow and an increment coincide, the counter is net unchanged.
  - A flush with `buf_valid`=1 or `resp_mine`=1 that same cycle does not increment.
  - Increment saturates; overflow is illegal (an assertion fires).
- **Stray responses:** a `data_ok` with `cancel_cnt`=0 and no waiting instruction is illegal (assertion).
- **Load data:**
  - `rdata` = `buf_valid ? rdata_buf : data_sram_rdata`.
  - Byte/half selection uses `addr_lo`:
    - byte = `rdata[8*addr_lo +: 8]`
    - half = `addr_lo[1] ? rdata[31:16] : rdata[15:0]`
  - `op_u` selects zero-extension; otherwise sign-extend.
  - Word when `~op_b & ~op_h`.
- **Result selection:** `final_result` = `res_from_mem ? load_data : alu_result`.
- **`data_pending`:** `mem_valid & res_from_mem & ~ready_go`. ID stalls on this.
- **Stores:** `data_ok` is consumed; no data is used.
- **Exceptions:** when `excep_en`/`ertn_flush` is set, `mem_req` is 0 by construction (EX suppresses the request), so such instructions pass with a 1-cycle latency.
- **Latency:** the zero-wait case (`data_ok` in the first MEM cycle) is 1 cycle in MEM.

Decomposition:
- **Shared package `pipe_bus_pkg`:**
  - Bus widths: EX2MEM_W=80, MEM2WB_W=72, MEM2ID_W=40, MEM2EX_W=3.
  - Field offset localparams.
  - Load-op encodings.
- **One sub-module, `load_align`:** combinational load extraction and extension (`rdata`, `addr_lo`, `op_b`/`op_h`/`op_u` → 32-bit result). It is reused later by the cache refill path.

Test Plan:
- `ld.b`, `alu_result`=0x1000_0003, `op_u`=0, `rdata`=0x80FF_1234, `data_ok` in the same cycle → `final_result`=0xFFFF_FF80; `mem_to_wb_valid` 1 cycle after acceptance.
- `ld.hu` at `addr_lo`=2, `rdata`=0xBEEF_0000, `data_ok` delayed 3 cycles → `data_pending`=1 for 3 cycles, `mem_allowin`=0 throughout, then `final_result`=0x0000_BEEF.
- `ld.w`, `data_ok`=1 with `rdata`=0xDEAD_BEEF while `wb_allowin`=0 for 2 cycles → `buf_valid`=1, WB receives 0xDEAD_BEEF when `wb_allowin` rises, and the bus output does not change when `data_sram_rdata` changes.
- `ld.w` outstanding + flush → `cancel_cnt`=1 and `mem_valid`=0. A new `ld.w` enters; the first `data_ok` (0x1111_1111) is swallowed and the second (0x2222_2222) yields `final_result`=0x2222_2222.
- Instruction with `excep_en`=1, `ertn_flush`=0, `srch_conflict`=1 → `mem_to_ex_bus`=3'b101, passes to WB in 1 cycle with no `data_ok` needed.
- Reset asserted mid-wait with `cancel_cnt`=1 → next cycle all state 0, `mem_allowin`=1, `mem_to_wb_valid`=0.
